uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX/RX byte paths.
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_LOW = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port byte array: synchronous write port and a registered, enabled read port.
module uart_fifo_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register holds its value between reads so the consumer sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and feeder in front of the UART transmitter.
// Optional level interrupt enabled by defining UART_TX_FIFO_LEVEL_IRQ_EN.
//
// state    | meaning
// IDLE     | waiting for a stored byte and transmitter TX-empty
// ISSUE    | write strobe to transmitter is high this cycle
// WAIT_LOW | waiting for TX-empty to drop (byte taken)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LEVEL_THR  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [BYTE_W-1:0]     i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovf,
    output logic                  o_tx_wr,
    output logic [BYTE_W-1:0]     o_tx_data,
    input  logic                  i_tx_txe,
    input  logic                  i_tx_txc,
    output logic                  o_busy,
    output logic                  o_irq
);

    localparam int AW = DEPTH_LOG2 + 1;

    if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8 || LEVEL_THR < 0 || LEVEL_THR > (1 << DEPTH_LOG2))
    begin : g_bad_cfg
        $error("uart_tx_fifo: DEPTH_LOG2 or LEVEL_THR out of range");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    tx_state_t     state;
    logic          active;
    logic          push;
    logic          pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr == {~rd_ptr[AW-1], rd_ptr[AW-2:0]});
    assign o_level = wr_ptr - rd_ptr;
    assign push    = i_wr & ~o_full;
    assign pop     = (state == IDLE) & ~o_empty & i_tx_txe;
    assign o_busy  = ~o_empty | (state != IDLE) | active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            o_ovf <= i_wr & o_full;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_tx_wr <= 1'b0;
            active  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= ISSUE;
                        o_tx_wr <= 1'b1;
                    end
                end
                ISSUE: begin
                    state   <= WAIT_LOW;
                    o_tx_wr <= 1'b0;
                end
                WAIT_LOW: begin
                    if (!i_tx_txe) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_tx_wr <= 1'b0;
                end
            endcase
            // A new issue outranks a completion seen in the same cycle.
            if (pop)           active <= 1'b1;
            else if (i_tx_txc) active <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .AW (DEPTH_LOG2),
        .DW (BYTE_W)
    ) u_mem (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-2:0]),
        .wr_data (i_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr[AW-2:0]),
        .rd_data (o_tx_data)
    );

`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
    logic armed;
    logic seen;
    logic irq;

    // No interrupt out of reset until the FIFO has actually been used.
    assign seen = armed | active | ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed <= 1'b0;
            irq   <= 1'b0;
        end else begin
            armed <= seen;
            irq   <= seen & (int'(o_level) <= LEVEL_THR);
        end
    end

    assign o_irq = irq;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a hand-driven transmitter model.
module tb_uart_tx_fifo;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_wr;
    logic [7:0] i_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       o_ovf;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic       i_tx_txe;
    logic       i_tx_txc;
    logic       o_busy;
    logic       o_irq;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    uart_tx_fifo #(
        .DEPTH_LOG2 (4),
        .LEVEL_THR  (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (i_wr),
        .i_data    (i_data),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_ovf     (o_ovf),
        .o_tx_wr   (o_tx_wr),
        .o_tx_data (o_tx_data),
        .i_tx_txe  (i_tx_txe),
        .i_tx_txc  (i_tx_txc),
        .o_busy    (o_busy),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        i_wr   = 1'b1;
        i_data = b;
        tick();
        i_wr   = 1'b0;
    endtask

    // Wait for a strobe, capture its byte, then play the transmitter handshake.
    task automatic send_one(output logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (o_tx_wr) ok = 1'b1;
            else tick();
        end
        d = o_tx_data;
        tick();
        i_tx_txe = 1'b0;
        tick();
        tick();
        i_tx_txc = 1'b1;
        tick();
        i_tx_txc = 1'b0;
        i_tx_txe = 1'b1;
    endtask

    logic [7:0] d;
    bit         ok;
    int         extra;

    initial begin
        i_rst_n  = 1'b0;
        i_wr     = 1'b0;
        i_data   = 8'h00;
        i_tx_txe = 1'b1;
        i_tx_txc = 1'b0;
        tick();
        tick();
        #2 i_rst_n = 1'b1;
        tick();

        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_level", o_level, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_tx_wr", o_tx_wr, 0);
        chk("rst_tx_data", o_tx_data, 8'h00);
        chk("rst_irq", o_irq, 0);

        // single byte, latency and busy
        push(8'hA5);
        chk("a5_level", o_level, 1);
        chk("a5_empty", o_empty, 0);
        chk("a5_no_early_wr", o_tx_wr, 0);
        tick();
        chk("a5_tx_wr", o_tx_wr, 1);
        chk("a5_tx_data", o_tx_data, 8'hA5);
        chk("a5_busy", o_busy, 1);
        send_one(d, ok);
        chk("a5_seen", ok, 1);
        chk("a5_busy_after_txc", o_busy, 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            if (o_tx_wr) extra++;
            tick();
        end
        chk("a5_single_strobe", extra, 0);

        // fill, overflow, drain in order
        i_tx_txe = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", o_full, 1);
        chk("fill_level", o_level, 16);
        chk("fill_no_ovf", o_ovf, 0);
        push(8'hFF);
        chk("ovf_pulse", o_ovf, 1);
        chk("ovf_level", o_level, 16);
        tick();
        chk("ovf_one_cycle", o_ovf, 0);
        i_tx_txe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_one(d, ok);
            chk("drain_seen", ok, 1);
            chk("drain_byte", d, 32'(i));
        end
        chk("drain_empty", o_empty, 1);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_tx_wr) extra++;
            tick();
        end
        chk("ff_never_sent", extra, 0);

        // push and pop on the same edge at level 3
        i_tx_txe = 1'b0;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        chk("pp_level_before", o_level, 3);
        i_wr     = 1'b1;
        i_data   = 8'h13;
        i_tx_txe = 1'b1;
        tick();
        i_wr = 1'b0;
        chk("pp_level", o_level, 3);
        chk("pp_no_ovf", o_ovf, 0);
        chk("pp_tx_wr", o_tx_wr, 1);
        chk("pp_tx_data", o_tx_data, 8'h10);
        for (int i = 0; i < 4; i++) begin
            send_one(d, ok);
            chk("pp_seen", ok, 1);
            chk("pp_byte", d, 32'h10 + 32'(i));
        end

        // reset while waiting for TX-empty to drop, level 5
        i_tx_txe = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        i_tx_txe = 1'b1;
        tick();
        chk("mid_issue", o_tx_wr, 1);
        tick();
        chk("mid_level", o_level, 5);
        chk("mid_busy", o_busy, 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("arst_empty", o_empty, 1);
        chk("arst_level", o_level, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_tx_data", o_tx_data, 8'h00);
        chk("arst_tx_wr", o_tx_wr, 0);
        chk("arst_irq", o_irq, 0);
        #1 i_rst_n = 1'b1;
        tick();
        chk("post_rst_empty", o_empty, 1);
        chk("post_rst_level", o_level, 0);
        chk("post_rst_tx_wr", o_tx_wr, 0);

        // level interrupt while draining from 8
        i_tx_txe = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        tick();
        chk("irq_level8", o_level, 8);
        chk("irq_at8", o_irq, 0);
        i_tx_txe = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            send_one(d, ok);
            chk("irq_seen", ok, 1);
            chk("irq_byte", d, 32'h30 + 32'(k - 1));
            chk("irq_level", o_irq, 32'(IRQ_EN && (8 - k) <= 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
